// File: rtl/mult_pkg.sv
// Shared types and helpers for the mult_seq shift-and-add unsigned multiplier.
package mult_pkg;

    // Widest product the overflow helper handles (INPUT_WIDTH up to 32).
    localparam int MAX_PROD_W = 64;

    typedef enum logic [0:0] {
        IDLE,
        CALC
    } mult_state_t;

    // True when any product bit at or above result_width is set; the caller zero-extends.
    function automatic logic calc_overflow(input logic [MAX_PROD_W-1:0] product,
                                           input int                    result_width);
        if (result_width >= MAX_PROD_W) begin
            return 1'b0;
        end
        return (product >> result_width) != '0;
    endfunction

endpackage

// File: rtl/mult_stage.sv
// One shift-and-add step: adds a when b[0] is set, then shifts a left and b right.
module mult_stage
    import mult_pkg::*;
#(
    parameter int INPUT_WIDTH = 16,
    parameter int USER_WIDTH  = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic [2*INPUT_WIDTH-1:0] acc_i,
    input  logic [2*INPUT_WIDTH-1:0] a_i,
    input  logic [INPUT_WIDTH-1:0]   b_i,
    input  logic [USER_WIDTH-1:0]    user_i,
    input  logic                     valid_i,
    output logic [2*INPUT_WIDTH-1:0] acc_o,
    output logic [2*INPUT_WIDTH-1:0] a_o,
    output logic [INPUT_WIDTH-1:0]   b_o,
    output logic [USER_WIDTH-1:0]    user_o,
    output logic                     valid_o
);

    // NOTE: sequential state is always assigned with <= so every stage samples the old value.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            valid_o <= 1'b0;
        end else begin
            valid_o <= valid_i;
        end
    end

    // NOTE: the datapath has no reset; valid qualifies it, so reset only the valid bit.
    always_ff @(posedge clk_i) begin
        acc_o  <= b_i[0] ? acc_i + a_i : acc_i;
        a_o    <= a_i << 1;
        b_o    <= b_i >> 1;
        user_o <= user_i;
    end

endmodule

// File: rtl/mult_seq.sv
// Unsigned shift-and-add multiplier: iterative FSM (PIPELINED=0) or INPUT_WIDTH+1 stage pipeline.
// Define MULT_SATURATE_EN to clamp overflowing results to all ones instead of wrapping.
module mult_seq
    import mult_pkg::*;
#(
    parameter int INPUT_WIDTH  = 16,
    parameter int RESULT_WIDTH = 32,
    parameter int PIPELINED    = 0,
    parameter int USER_WIDTH   = 1
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic [INPUT_WIDTH-1:0]  operand_a_i,
    input  logic [INPUT_WIDTH-1:0]  operand_b_i,
    input  logic [USER_WIDTH-1:0]   user_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    output logic [RESULT_WIDTH-1:0] result_o,
    output logic [USER_WIDTH-1:0]   user_o,
    output logic                    overflow_o,
    output logic                    valid_o
);

    localparam int PROD_W = 2 * INPUT_WIDTH;
    localparam int CNT_W  = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    logic                    ready_q;
    logic                    accept;
    logic                    fin;
    logic [PROD_W-1:0]       fin_prod;
    logic [USER_WIDTH-1:0]   fin_user;
    logic                    ovf_d;
    logic [RESULT_WIDTH-1:0] res_d;

    assign ready_o = ready_q;
    assign accept  = valid_i && ready_q;

    generate
        if (PIPELINED == 0) begin : g_iter
            mult_state_t             state_q, state_d;
            logic                    ready_d;
            logic                    fin_q, fin_d;
            logic                    load, step, zero_op;
            logic [PROD_W-1:0]       acc_q, a_q;
            logic [INPUT_WIDTH-1:0]  b_q;
            logic [USER_WIDTH-1:0]   user_q;
            logic [CNT_W-1:0]        cnt_q;

            assign zero_op = (operand_a_i == '0) || (operand_b_i == '0);

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    state_q <= IDLE;
                    ready_q <= 1'b0;
                    fin_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= ready_d;
                    fin_q   <= fin_d;
                end
            end

            // NOTE: every always_comb output gets a default first, so no path infers a latch.
            always_comb begin
                state_d = state_q;
                fin_d   = 1'b0;
                load    = 1'b0;
                step    = 1'b0;
                case (state_q)
                    IDLE: begin
                        if (accept) begin
                            load = 1'b1;
                            if (zero_op) begin
                                fin_d = 1'b1;
                            end else begin
                                state_d = CALC;
                            end
                        end
                    end
                    CALC: begin
                        step = 1'b1;
                        if (cnt_q == '0) begin
                            state_d = IDLE;
                            fin_d   = 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
                ready_d = (state_d == IDLE);
            end

            // Same add/shift step as mult_stage, applied once per CALC cycle.
            always_ff @(posedge clk_i) begin
                if (load) begin
                    acc_q  <= '0;
                    a_q    <= {{INPUT_WIDTH{1'b0}}, operand_a_i};
                    b_q    <= operand_b_i;
                    user_q <= user_i;
                    cnt_q  <= CNT_W'(INPUT_WIDTH - 1);
                end else if (step) begin
                    if (b_q[0]) begin
                        acc_q <= acc_q + a_q;
                    end
                    a_q   <= a_q << 1;
                    b_q   <= b_q >> 1;
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            assign fin      = fin_q;
            assign fin_prod = acc_q;
            assign fin_user = user_q;
        end else begin : g_pipe
            logic                   s0_valid;
            logic [INPUT_WIDTH-1:0] s0_a, s0_b;
            logic [USER_WIDTH-1:0]  s0_user;
            logic [PROD_W-1:0]      acc_c  [INPUT_WIDTH+1];
            logic [PROD_W-1:0]      a_c    [INPUT_WIDTH+1];
            logic [INPUT_WIDTH-1:0] b_c    [INPUT_WIDTH+1];
            logic [USER_WIDTH-1:0]  user_c [INPUT_WIDTH+1];
            logic                   valid_c[INPUT_WIDTH+1];

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    ready_q  <= 1'b0;
                    s0_valid <= 1'b0;
                end else begin
                    ready_q  <= 1'b1;
                    s0_valid <= accept;
                end
            end

            always_ff @(posedge clk_i) begin
                s0_a    <= operand_a_i;
                s0_b    <= operand_b_i;
                s0_user <= user_i;
            end

            assign acc_c[0]   = '0;
            assign a_c[0]     = {{INPUT_WIDTH{1'b0}}, s0_a};
            assign b_c[0]     = s0_b;
            assign user_c[0]  = s0_user;
            assign valid_c[0] = s0_valid;

            for (genvar k = 0; k < INPUT_WIDTH; k++) begin : g_stage
                mult_stage #(
                    .INPUT_WIDTH(INPUT_WIDTH),
                    .USER_WIDTH (USER_WIDTH)
                ) u_stage (
                    .clk_i   (clk_i),
                    .reset_ni(reset_ni),
                    .acc_i   (acc_c[k]),
                    .a_i     (a_c[k]),
                    .b_i     (b_c[k]),
                    .user_i  (user_c[k]),
                    .valid_i (valid_c[k]),
                    .acc_o   (acc_c[k+1]),
                    .a_o     (a_c[k+1]),
                    .b_o     (b_c[k+1]),
                    .user_o  (user_c[k+1]),
                    .valid_o (valid_c[k+1])
                );
            end

            assign fin      = valid_c[INPUT_WIDTH];
            assign fin_prod = acc_c[INPUT_WIDTH];
            assign fin_user = user_c[INPUT_WIDTH];
        end
    endgenerate

    always_comb begin
        ovf_d = calc_overflow(MAX_PROD_W'(fin_prod), RESULT_WIDTH);
        res_d = fin_prod[RESULT_WIDTH-1:0];
`ifdef MULT_SATURATE_EN
        if (ovf_d) begin
            res_d = '1;
        end
`endif
    end

    // Output register holds its contents between valid_o pulses.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            result_o   <= '0;
            user_o     <= '0;
            overflow_o <= 1'b0;
            valid_o    <= 1'b0;
        end else begin
            valid_o <= fin;
            if (fin) begin
                result_o   <= res_d;
                user_o     <= fin_user;
                overflow_o <= ovf_d;
            end
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: iterative 16/32, pipelined 16/32 and iterative 16/16 instances.
module tb_mult_seq;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b0;
    logic [15:0] op_a [3];
    logic [15:0] op_b [3];
    logic [1:0]  op_u [3];
    logic        op_v [3];

    logic        rdy_it, vld_it, ovf_it, rdy_pp, vld_pp, ovf_pp, rdy_nr, vld_nr, ovf_nr;
    logic [31:0] res_it, res_pp;
    logic [15:0] res_nr;
    logic [1:0]  usr_it, usr_pp, usr_nr;

    logic [31:0] obs_res [3];
    logic [1:0]  obs_usr [3];
    logic        obs_vld [3];
    logic        obs_rdy [3];
    logic        obs_ovf [3];

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    mult_seq #(.INPUT_WIDTH(16), .RESULT_WIDTH(32), .PIPELINED(0), .USER_WIDTH(2)) u_dut_it (
        .clk_i(clk_i), .reset_ni(reset_ni), .operand_a_i(op_a[0]), .operand_b_i(op_b[0]),
        .user_i(op_u[0]), .valid_i(op_v[0]), .ready_o(rdy_it), .result_o(res_it),
        .user_o(usr_it), .overflow_o(ovf_it), .valid_o(vld_it));

    mult_seq #(.INPUT_WIDTH(16), .RESULT_WIDTH(32), .PIPELINED(1), .USER_WIDTH(2)) u_dut_pp (
        .clk_i(clk_i), .reset_ni(reset_ni), .operand_a_i(op_a[1]), .operand_b_i(op_b[1]),
        .user_i(op_u[1]), .valid_i(op_v[1]), .ready_o(rdy_pp), .result_o(res_pp),
        .user_o(usr_pp), .overflow_o(ovf_pp), .valid_o(vld_pp));

    mult_seq #(.INPUT_WIDTH(16), .RESULT_WIDTH(16), .PIPELINED(0), .USER_WIDTH(2)) u_dut_nr (
        .clk_i(clk_i), .reset_ni(reset_ni), .operand_a_i(op_a[2]), .operand_b_i(op_b[2]),
        .user_i(op_u[2]), .valid_i(op_v[2]), .ready_o(rdy_nr), .result_o(res_nr),
        .user_o(usr_nr), .overflow_o(ovf_nr), .valid_o(vld_nr));

    assign obs_res[0] = res_it;  assign obs_res[1] = res_pp;  assign obs_res[2] = {16'h0, res_nr};
    assign obs_usr[0] = usr_it;  assign obs_usr[1] = usr_pp;  assign obs_usr[2] = usr_nr;
    assign obs_vld[0] = vld_it;  assign obs_vld[1] = vld_pp;  assign obs_vld[2] = vld_nr;
    assign obs_rdy[0] = rdy_it;  assign obs_rdy[1] = rdy_pp;  assign obs_rdy[2] = rdy_nr;
    assign obs_ovf[0] = ovf_it;  assign obs_ovf[1] = ovf_pp;  assign obs_ovf[2] = ovf_nr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: full product by plain arithmetic, then keep the low rw bits.
    function automatic void model(input logic [15:0] aa, input logic [15:0] bb, input int rw,
                                  output logic [63:0] res, output logic ovf);
        logic [63:0] p, mask;
        p    = 64'(aa) * 64'(bb);
        mask = (64'd1 << rw) - 64'd1;
        ovf  = (p & ~mask) != 64'd0;
        res  = p & mask;
`ifdef MULT_SATURATE_EN
        if (ovf) res = mask;
`endif
    endfunction

    function automatic int rw_of(input int d);
        return (d == 2) ? 16 : 32;
    endfunction

    // Issue one op on an iterative instance and check latency, payload and hold.
    task automatic op_check(input int d, input logic [15:0] aa, input logic [15:0] bb,
                            input logic [1:0] uu, input string tag);
        int          n, lat;
        logic [63:0] er;
        logic        eo;
        model(aa, bb, rw_of(d), er, eo);
        lat = (aa == 16'h0 || bb == 16'h0) ? 1 : 17;
        n = 0;
        @(negedge clk_i);
        while (!obs_rdy[d] && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_ready"}, 64'(obs_rdy[d]), 64'd1);
        op_a[d] = aa; op_b[d] = bb; op_u[d] = uu; op_v[d] = 1'b1;
        @(negedge clk_i);
        op_v[d] = 1'b0;
        n = 0;
        while (!obs_vld[d] && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_lat"}, 64'(n), 64'(lat));
        check({tag, "_res"}, 64'(obs_res[d]), er);
        check({tag, "_usr"}, 64'(obs_usr[d]), 64'(uu));
        check({tag, "_ovf"}, 64'(obs_ovf[d]), 64'(eo));
        @(negedge clk_i);
        check({tag, "_pulse"}, 64'(obs_vld[d]), 64'd0);
        check({tag, "_hold"}, 64'(obs_res[d]), er);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [15:0] st_a [40];
    logic [15:0] st_b [40];
    logic [1:0]  st_u [40];
    logic        st_v [40];

    initial begin
        int          low_cnt, pulses, pulse_k, n;
        logic [31:0] got_res;
        logic [63:0] er;
        logic        eo;

        for (int d = 0; d < 3; d++) begin
            op_a[d] = '0; op_b[d] = '0; op_u[d] = '0; op_v[d] = 1'b0;
        end

        // Reset state and ready release
        repeat (3) @(negedge clk_i);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_res%0d", d), 64'(obs_res[d]), 64'd0);
            check($sformatf("rst_vld%0d", d), 64'(obs_vld[d]), 64'd0);
            check($sformatf("rst_rdy%0d", d), 64'(obs_rdy[d]), 64'd0);
            check($sformatf("rst_ovf%0d", d), 64'(obs_ovf[d]), 64'd0);
            check($sformatf("rst_usr%0d", d), 64'(obs_usr[d]), 64'd0);
        end
        reset_ni = 1'b1;
        check("rel_rdy_pre", 64'(obs_rdy[0]), 64'd0);
        @(negedge clk_i);
        for (int d = 0; d < 3; d++) check($sformatf("rel_rdy%0d", d), 64'(obs_rdy[d]), 64'd1);

        // Iterative directed ops
        op_check(0, 16'd3, 16'd5, 2'd1, "it_3x5");
        op_check(0, 16'hFFFF, 16'hFFFF, 2'd2, "it_max");

        // Zero op followed by an op accepted on the very next cycle
        @(negedge clk_i);
        op_a[0] = 16'd0; op_b[0] = 16'd1234; op_u[0] = 2'd1; op_v[0] = 1'b1;
        @(negedge clk_i);
        check("b2b_ready", 64'(obs_rdy[0]), 64'd1);
        op_a[0] = 16'd7; op_b[0] = 16'd9; op_u[0] = 2'd2;
        @(negedge clk_i);
        op_v[0] = 1'b0;
        check("zero_vld", 64'(obs_vld[0]), 64'd1);
        check("zero_res", 64'(obs_res[0]), 64'd0);
        check("zero_usr", 64'(obs_usr[0]), 64'd1);
        check("zero_ovf", 64'(obs_ovf[0]), 64'd0);
        @(negedge clk_i);
        n = 1;
        while (!obs_vld[0] && n < 40) begin
            @(negedge clk_i);
            n++;
        end
        check("b2b_lat", 64'(n), 64'd17);
        check("b2b_res", 64'(obs_res[0]), 64'd63);
        check("b2b_usr", 64'(obs_usr[0]), 64'd2);

        // Busy: valid while ready is low is dropped
        @(negedge clk_i);
        op_a[0] = 16'd2; op_b[0] = 16'd3; op_u[0] = 2'd2; op_v[0] = 1'b1;
        @(negedge clk_i);
        op_a[0] = 16'd100; op_b[0] = 16'd100; op_u[0] = 2'd3;
        low_cnt = 0; pulses = 0; pulse_k = -1; got_res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) op_v[0] = 1'b0;
            if (obs_vld[0]) begin
                pulses++;
                got_res = obs_res[0];
                pulse_k = k;
            end
            if (!obs_rdy[0] && low_cnt == k) low_cnt++;
            @(negedge clk_i);
        end
        check("busy_low", 64'(low_cnt), 64'd16);
        check("busy_pulses", 64'(pulses), 64'd1);
        check("busy_lat", 64'(pulse_k), 64'd17);
        check("busy_res", 64'(got_res), 64'd6);

        // Randomized iterative ops, some with a zero operand
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 3) == 0) ra = 16'h0;
            op_check(0, ra, rb, 2'($urandom), $sformatf("it_rnd%0d", i));
        end

        // Narrow result width: wrap vs saturate, and an exact fit
        op_check(2, 16'h1000, 16'h0010, 2'd1, "nr_ovf");
        op_check(2, 16'h00FF, 16'h0100, 2'd2, "nr_fit");
        for (int i = 0; i < 4; i++) begin
            op_check(2, 16'($urandom), 16'($urandom_range(0, 3)), 2'($urandom), $sformatf("nr_rnd%0d", i));
        end

        // Pipelined: directed burst then random stream with gaps
        st_a[0] = 16'd1;     st_b[0] = 16'd1;     st_u[0] = 2'd0; st_v[0] = 1'b1;
        st_a[1] = 16'd2;     st_b[1] = 16'd3;     st_u[1] = 2'd1; st_v[1] = 1'b1;
        st_a[2] = 16'h0100;  st_b[2] = 16'h0100;  st_u[2] = 2'd2; st_v[2] = 1'b1;
        st_a[3] = 16'hFFFF;  st_b[3] = 16'd2;     st_u[3] = 2'd3; st_v[3] = 1'b1;
        for (int i = 4; i < 40; i++) begin
            st_a[i] = 16'($urandom);
            st_b[i] = 16'($urandom);
            st_u[i] = 2'($urandom);
            st_v[i] = (i >= 10) && ($urandom_range(0, 3) != 0);
        end
        st_a[12] = 16'h0; st_v[12] = 1'b1;
        st_v[13] = 1'b1;
        for (int j = 0; j < 58; j++) begin
            @(negedge clk_i);
            check($sformatf("pp_rdy%0d", j), 64'(obs_rdy[1]), 64'd1);
            if (j >= 18 && st_v[j-18]) begin
                model(st_a[j-18], st_b[j-18], 32, er, eo);
                check($sformatf("pp_vld%0d", j), 64'(obs_vld[1]), 64'd1);
                check($sformatf("pp_res%0d", j), 64'(obs_res[1]), er);
                check($sformatf("pp_usr%0d", j), 64'(obs_usr[1]), 64'(st_u[j-18]));
                check($sformatf("pp_ovf%0d", j), 64'(obs_ovf[1]), 64'(eo));
            end else begin
                check($sformatf("pp_vld%0d", j), 64'(obs_vld[1]), 64'd0);
            end
            if (j < 40) begin
                op_a[1] = st_a[j]; op_b[1] = st_b[j]; op_u[1] = st_u[j]; op_v[1] = st_v[j];
            end else begin
                op_v[1] = 1'b0;
            end
        end

        // Reset in the middle of an iterative op
        op_check(0, 16'd11, 16'd13, 2'd1, "pre_rst");
        @(negedge clk_i);
        op_a[0] = 16'd5; op_b[0] = 16'd5; op_u[0] = 2'd3; op_v[0] = 1'b1;
        @(negedge clk_i);
        op_v[0] = 1'b0;
        repeat (7) @(negedge clk_i);
        @(posedge clk_i);
        #2 reset_ni = 1'b0;
        #1;
        check("mid_rst_res", 64'(obs_res[0]), 64'd0);
        check("mid_rst_usr", 64'(obs_usr[0]), 64'd0);
        check("mid_rst_ovf", 64'(obs_ovf[0]), 64'd0);
        check("mid_rst_vld", 64'(obs_vld[0]), 64'd0);
        check("mid_rst_rdy", 64'(obs_rdy[0]), 64'd0);
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;
        check("mid_rel_rdy_pre", 64'(obs_rdy[0]), 64'd0);
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk_i);
            if (k == 0) check("mid_rel_rdy", 64'(obs_rdy[0]), 64'd1);
            if (obs_vld[0]) pulses++;
        end
        check("mid_rst_nopulse", 64'(pulses), 64'd0);
        op_check(0, 16'd4, 16'd4, 2'd2, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Unsigned integer multiplier; the inverse companion of the unsigned integer divider in the DSP arithmetic library.
- Computes numerator-style operand_a × operand_b using shift-and-add.
- Two compile-time architectures: an iterative FSM (one partial product per cycle, area-lean) and a fully pipelined chain (one result per cycle).
- Carries a user sideband alongside each operation; used for PSS/SSS amplitude scaling and FFT bin-index arithmetic.

Parameters:
- INPUT_WIDTH, 16, width of each unsigned operand.
- RESULT_WIDTH, 32, width of result_o. Valid range 1..2*INPUT_WIDTH; the full product is 2*INPUT_WIDTH bits.
- PIPELINED, 0, 0 selects the iterative FSM; 1 selects the INPUT_WIDTH+1 stage pipeline.
- USER_WIDTH, 1, width of the sideband passed through with each operation.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  reset; asynchronous, active-low.
- operand_a_i  in  INPUT_WIDTH  multiplicand.
- operand_b_i  in  INPUT_WIDTH  multiplier.
- user_i  in  USER_WIDTH  sideband, captured at acceptance.
- valid_i  in  1  operands valid; accepted when valid_i && ready_o.
- ready_o  out  1  block can accept an operation this cycle.
- result_o  out  RESULT_WIDTH  product.
- user_o  out  USER_WIDTH  sideband matching result_o.
- overflow_o  out  1  product did not fit RESULT_WIDTH; qualified by valid_o.
- valid_o  out  1  single-cycle pulse marking result_o, user_o and overflow_o.

Behaviour:
- Reset (async assert, sync release): result_o=0, user_o=0, overflow_o=0, valid_o=0, ready_o=0, FSM→IDLE, all pipeline valids cleared.
  - Reset asserted mid-operation aborts the operation; no valid_o is produced for it.
  - ready_o rises on the first clock edge after reset_ni deasserts.
- No backpressure: valid_o is not stalled and the consumer always accepts.
- Iterative mode (PIPELINED=0), FSM states IDLE and CALC:
  - IDLE: ready_o=1. On valid_i, latch a, b and user.
    - If a==0 or b==0: result_o=0, overflow_o=0, valid_o=1 on the next edge; stay in IDLE.
    - Otherwise: accumulator=0, bit counter=INPUT_WIDTH-1, ready_o=0, go to CALC.
  - CALC: each cycle, if b[0]==1 then accumulator += a_shifted; then a_shifted <<= 1 and b >>= 1; counter decrements.
    - When counter==0: register the final result, assert valid_o for one cycle, set ready_o=1, go to IDLE.
  - Latency: valid_o asserts exactly INPUT_WIDTH+1 edges after acceptance for nonzero operands, 1 edge after acceptance for zero operands.
  - valid_i while ready_o=0 is ignored; the operation is dropped and the upstream holds valid_i.
  - Back-to-back: a new op can be accepted in the same cycle that valid_o is asserted, because ready_o is already 1.
- Pipelined mode (PIPELINED=1):
  - ready_o=1 continuously after reset.
  - Stage 0 registers the inputs; stage k (1..INPUT_WIDTH) adds a<<(k-1) when bit k-1 of b is 1.
  - Fixed latency INPUT_WIDTH+1; throughput one op per cycle; results delivered in order; user and valid travel with the data.
  - Zero operands take no special path and produce 0 at the same latency.
- Width rule:
  - The accumulator is 2*INPUT_WIDTH bits internally and never wraps.
  - result_o = low RESULT_WIDTH bits of the product.
  - overflow_o = 1 when any discarded upper bit is 1. It is computed in both modes and is constant 0 when RESULT_WIDTH = 2*INPUT_WIDTH.
  - All outputs hold their values between valid_o pulses.

Optional Feature:
- Macro MULT_SATURATE_EN.
- Defined: when overflow is detected, result_o = all ones (2^RESULT_WIDTH − 1) and overflow_o=1.
- Undefined: result_o is truncated to the low bits (wrap-around) and overflow_o still flags the overflow.
- Affects only the final output register; latency is unchanged.

Decomposition:
- Package mult_pkg holds:
  - typedef mult_state_t enum {IDLE, CALC};
  - function calc_overflow(product, RESULT_WIDTH).
- Sub-module mult_stage: one shift-add stage carrying accumulator, a, b, user and valid.
  - Instantiated INPUT_WIDTH times by a generate loop in pipelined mode.
  - The iterative FSM reuses the same add logic inline.

Test Plan:
- Iterative, 16/32: a=3, b=5, user=1 → valid_o exactly 17 edges later with result_o=15, user_o=1, overflow_o=0. Also a=0xFFFF, b=0xFFFF → result_o=0xFFFE0001.
- Iterative: a=0, b=1234 → valid_o one edge later, result_o=0. Next op a=7, b=9 is accepted on the following cycle → result_o=63.
- Iterative busy: accept a=2, b=3; drive a=100, b=100 for 10 cycles while ready_o=0 → only result 6 is emitted; ready_o stays low for 16 cycles after acceptance.
- Pipelined: 4 back-to-back ops (1×1, 2×3, 0x100×0x100, 0xFFFF×2) with user 0..3 → four consecutive valid_o pulses starting 17 edges after the first, giving results 1, 6, 0x10000, 0x1FFFE with user 0..3 in order.
- RESULT_WIDTH=16: a=0x1000, b=0x0010 → without the macro result_o=0x0000 and overflow_o=1; with MULT_SATURATE_EN result_o=0xFFFF and overflow_o=1. Also a=0x00FF, b=0x0100 → 0xFF00 with overflow_o=0.
- Reset mid-op: accept 5×5, assert reset_ni=0 asynchronously at cycle 8 → all outputs 0 immediately and no valid_o afterwards; after release, ready_o=1 and 4×4 → 16.
